stopwatch_bcd: RTL and testbench

//  mm:ss stopwatch that drives four_hex_in of the 4-digit display driver.

---
 rtl/stopwatch_bcd_pkg.sv | 58 +++++
 rtl/stopwatch_bcd_if.sv | 21 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/stopwatch_bcd.sv | 109 ++++++++++
 tb/tb_stopwatch_bcd.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and constants for the mm:ss stopwatch and the blocks that will reuse its time format.
// Holds the FSM state encoding, the BCD digit limits and the BCD increment helper.
package stopwatch_bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned TIME_W  = 4 * DIGIT_W;

    localparam logic [DIGIT_W-1:0] BCD_MAX_ONES = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
    } bcd_time_t;

    typedef struct packed {
        logic      wrap;
        bcd_time_t t;
    } bcd_inc_t;

    // Ripple-carry BCD add-one; '>=' folds any out-of-range digit back to zero.
    function automatic bcd_inc_t bcd_increment(input bcd_time_t cur);
        bcd_inc_t r;
        r.wrap = 1'b0;
        r.t    = cur;
        if (cur.sec_ones >= BCD_MAX_ONES) begin
            r.t.sec_ones = '0;
            if (cur.sec_tens >= BCD_MAX_TENS) begin
                r.t.sec_tens = '0;
                if (cur.min_ones >= BCD_MAX_ONES) begin
                    r.t.min_ones = '0;
                    if (cur.min_tens >= BCD_MAX_TENS) begin
                        r.t.min_tens = '0;
                        r.wrap       = 1'b1;
                    end else begin
                        r.t.min_tens = cur.min_tens + 4'd1;
                    end
                end else begin
                    r.t.min_ones = cur.min_ones + 4'd1;
                end
            end else begin
                r.t.sec_tens = cur.sec_tens + 4'd1;
            end
        end else begin
            r.t.sec_ones = cur.sec_ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Stopwatch I/O bundle: raw inputs from the board/display and the BCD time fed to four_hex_in.
interface stopwatch_bcd_if;
    import stopwatch_bcd_pkg::*;

    logic              second_toggle;
    logic              btn_start;
    logic              btn_clear;
    logic [TIME_W-1:0] four_hex_out;
    logic              running;
    logic              wrap_pulse;

    modport master (
        output second_toggle, btn_start, btn_clear,
        input  four_hex_out, running, wrap_pulse
    );

    modport slave (
        input  second_toggle, btn_start, btn_clear,
        output four_hex_out, running, wrap_pulse
    );
endinterface

// File: rtl/btn_debounce.sv
// Synchronises and debounces one raw push-button; press pulses once per debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned CNT_W           = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only advances while the synced input disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// mm:ss BCD stopwatch counting the display's 1 Hz second_toggle, with start/stop and clear buttons.
module stopwatch_bcd
    import stopwatch_bcd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned CNT_W           = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_bcd_if.slave   sw
);

    logic      tick_s1_q, tick_s2_q, tick_prev_q;
    logic      tick_c;
    logic      start_press, clear_press;
    logic      start_lvl_unused, clear_lvl_unused;
    sw_state_e state_q, state_d;
    bcd_time_t count_q, count_d;
    bcd_inc_t  inc;
    logic      wrap_q, wrap_d;
    logic      running_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_start (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw.btn_start),
        .level (start_lvl_unused),
        .press (start_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw.btn_clear),
        .level (clear_lvl_unused),
        .press (clear_press)
    );

    // Either edge of the synced second_toggle is one second.
    assign tick_c = tick_s2_q ^ tick_prev_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        inc     = bcd_increment(count_q);
        unique case (state_q)
            ST_IDLE: begin
                if (clear_press) begin
                    count_d = '0;
                end else if (start_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick_c) begin
                    count_d = inc.t;
                    wrap_d  = inc.wrap;
                end
                if (start_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clear_press) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (start_press) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_s1_q   <= 1'b0;
            tick_s2_q   <= 1'b0;
            tick_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            count_q     <= '0;
            wrap_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            tick_s1_q   <= sw.second_toggle;
            tick_s2_q   <= tick_s1_q;
            tick_prev_q <= tick_s2_q;
            state_q     <= state_d;
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            running_q   <= (state_d == ST_RUN);
        end
    end

    assign sw.four_hex_out = count_q;
    assign sw.running      = running_q;
    assign sw.wrap_pulse   = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with short debounce: tick latency, buttons, bounce, wrap, clear and async reset.
module tb_stopwatch_bcd;
    import stopwatch_bcd_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n_run_chg;
    logic run_prev;

    stopwatch_bcd_if sw_if ();

    stopwatch_bcd #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every change of running seen at the sampling edge.
    initial begin
        n_run_chg = 0;
        run_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (sw_if.running !== run_prev) n_run_chg++;
            run_prev = sw_if.running;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic toggle_sec();
        sw_if.second_toggle = ~sw_if.second_toggle;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input logic st, input logic cl);
        sw_if.btn_start = st;
        sw_if.btn_clear = cl;
        repeat (6) @(negedge clk);
        sw_if.btn_start = 1'b0;
        sw_if.btn_clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int chg_before;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        sw_if.second_toggle = 1'b1;
        sw_if.btn_start     = 1'b0;
        sw_if.btn_clear     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_time", sw_if.four_hex_out, 16'h0000);
        check("rst_running", 16'(sw_if.running), 16'h0);
        check("rst_wrap", 16'(sw_if.wrap_pulse), 16'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Ticks in IDLE are dropped.
        repeat (5) toggle_sec();
        check("idle_time", sw_if.four_hex_out, 16'h0000);
        check("idle_running", 16'(sw_if.running), 16'h0);

        press(1'b1, 1'b0);
        check("start_running", 16'(sw_if.running), 16'h1);

        // Update lands two edges after the toggle is captured.
        sw_if.second_toggle = ~sw_if.second_toggle;
        @(negedge clk);
        @(negedge clk);
        check("tick_lat_before", sw_if.four_hex_out, 16'h0000);
        @(negedge clk);
        check("tick_lat_after", sw_if.four_hex_out, 16'h0001);
        repeat (60) toggle_sec();
        check("run_0101", sw_if.four_hex_out, 16'h0101);
        check("run_running", 16'(sw_if.running), 16'h1);

        // Bouncing start: one press only, RUN -> PAUSE.
        chg_before = n_run_chg;
        sw_if.btn_start = 1'b1; @(negedge clk);
        sw_if.btn_start = 1'b0; @(negedge clk);
        sw_if.btn_start = 1'b1; @(negedge clk);
        sw_if.btn_start = 1'b0; @(negedge clk);
        press(1'b1, 1'b0);
        check("bounce_changes", 16'(n_run_chg - chg_before), 16'd1);
        check("bounce_paused", 16'(sw_if.running), 16'h0);
        check("bounce_hold_time", sw_if.four_hex_out, 16'h0101);

        press(1'b1, 1'b0);
        check("resume_running", 16'(sw_if.running), 16'h1);

        // 01:01 + 3537 s = 59:58.
        repeat (3537) toggle_sec();
        check("preload_5958", sw_if.four_hex_out, 16'h5958);
        toggle_sec();
        check("at_5959", sw_if.four_hex_out, 16'h5959);
        sw_if.second_toggle = ~sw_if.second_toggle;
        @(negedge clk);
        @(negedge clk);
        check("wrap_pre_time", sw_if.four_hex_out, 16'h5959);
        check("wrap_pre_pulse", 16'(sw_if.wrap_pulse), 16'h0);
        @(negedge clk);
        check("wrap_time", sw_if.four_hex_out, 16'h0000);
        check("wrap_pulse", 16'(sw_if.wrap_pulse), 16'h1);
        @(negedge clk);
        check("wrap_pulse_end", 16'(sw_if.wrap_pulse), 16'h0);
        check("wrap_still_running", 16'(sw_if.running), 16'h1);

        repeat (12) toggle_sec();
        check("run_0012", sw_if.four_hex_out, 16'h0012);
        press(1'b0, 1'b1);
        check("clear_ign_time", sw_if.four_hex_out, 16'h0012);
        check("clear_ign_running", 16'(sw_if.running), 16'h1);
        press(1'b1, 1'b0);
        check("pause_running", 16'(sw_if.running), 16'h0);
        toggle_sec();
        check("pause_tick_drop", sw_if.four_hex_out, 16'h0012);
        press(1'b1, 1'b1);
        check("both_time", sw_if.four_hex_out, 16'h0000);
        check("both_running", 16'(sw_if.running), 16'h0);

        // 227 s = 03:47, then asynchronous reset between edges.
        press(1'b1, 1'b0);
        repeat (227) toggle_sec();
        check("run_0347", sw_if.four_hex_out, 16'h0347);
        #2 rst_n = 1'b0;
        #1;
        check("async_time", sw_if.four_hex_out, 16'h0000);
        check("async_running", 16'(sw_if.running), 16'h0);
        check("async_wrap", 16'(sw_if.wrap_pulse), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
